// File: rtl/mod_exp_ctrl_if.sv
// Command and multiplier bus of the modular-exponentiation sequencer.
// The sequencer takes the slave modport; the command layer / multiplier side takes master.
interface mod_exp_ctrl_if #(
    parameter int unsigned NBITS = 128,
    parameter int unsigned EBITS = 128,
    parameter int unsigned PBITS = 2
);
    // Command side
    logic                   start;
    logic [NBITS-1:0]       base;
    logic [EBITS-1:0]       exp;
    logic [NBITS-1:0]       m;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [NBITS-1:0]       result;

    // Multiplier side
    logic                   mm_enable_p;
    logic [NBITS-1:0]       mm_a;
    logic [NBITS-1:0]       mm_b;
    logic [NBITS-1:0]       mm_m;
    logic [NBITS+PBITS-1:0] mm_mx3;
    logic [NBITS-1:0]       mm_y;
    logic                   mm_done_p;

    modport slave (
        input  start, base, exp, m, mm_y, mm_done_p,
        output busy, done, err, result, mm_enable_p, mm_a, mm_b, mm_m, mm_mx3
    );

    modport master (
        output start, base, exp, m, mm_y, mm_done_p,
        input  busy, done, err, result, mm_enable_p, mm_a, mm_b, mm_m, mm_mx3
    );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right binary square-and-multiply sequencer for base^exp mod m.
// Drives one external modular multiplier, one multiply in flight at a time.
module mod_exp_ctrl #(
    parameter int unsigned NBITS = 128,
    parameter int unsigned EBITS = 128,
    parameter int unsigned PBITS = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mod_exp_ctrl_if.slave  bus
);

    localparam int unsigned CW = $clog2(EBITS + 1);
    localparam int unsigned MW = NBITS + PBITS;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StScan,
        StSqIssue,
        StSqWait,
        StMuIssue,
        StMuWait,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] base_q, base_d;
    logic [EBITS-1:0] exp_q, exp_d;
    logic [NBITS-1:0] m_q, m_d;
    logic [MW-1:0]    mx3_q, mx3_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] r_q, r_d;
    logic [NBITS-1:0] res_q, res_d;
    logic             err_q, err_d;

    logic             ebit;
    logic [EBITS-1:0] exp_sh;
    logic [CW-1:0]    cnt_dec;

    // Exponent bit under scan is always the MSB; consuming it shifts and counts down.
    assign ebit    = exp_q[EBITS-1];
    assign exp_sh  = exp_q << 1;
    assign cnt_dec = cnt_q - CW'(1);

    // Next-state logic and datapath updates.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        exp_d   = exp_q;
        m_d     = m_q;
        mx3_d   = mx3_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        res_d   = res_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    base_d  = bus.base;
                    exp_d   = bus.exp;
                    m_d     = bus.m;
                    // Widened before the add so 3*m is exact.
                    mx3_d   = MW'(bus.m) + (MW'(bus.m) << 1);
                    cnt_d   = CW'(EBITS);
                    err_d   = 1'b0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (m_q == '0 || base_q >= m_q) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = StDone;
                end else if (exp_q == '0) begin
                    res_d   = (m_q == NBITS'(1)) ? '0 : NBITS'(1);
                    state_d = StDone;
                end else begin
                    state_d = StScan;
                end
            end
            StScan: begin
                // Skip leading zeros; the first set bit seeds R with the base.
                exp_d = exp_sh;
                cnt_d = cnt_dec;
                if (ebit) begin
                    r_d = base_q;
                    if (cnt_dec == '0) begin
                        res_d   = base_q;
                        state_d = StDone;
                    end else begin
                        state_d = StSqIssue;
                    end
                end
            end
            StSqIssue: state_d = StSqWait;
            StSqWait: begin
                if (bus.mm_done_p) begin
                    r_d   = bus.mm_y;
                    exp_d = exp_sh;
                    cnt_d = cnt_dec;
                    if (ebit) begin
                        state_d = StMuIssue;
                    end else if (cnt_dec != '0) begin
                        state_d = StSqIssue;
                    end else begin
                        res_d   = bus.mm_y;
                        state_d = StDone;
                    end
                end
            end
            StMuIssue: state_d = StMuWait;
            StMuWait: begin
                if (bus.mm_done_p) begin
                    r_d = bus.mm_y;
                    if (cnt_q != '0) begin
                        state_d = StSqIssue;
                    end else begin
                        res_d   = bus.mm_y;
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            exp_q   <= '0;
            m_q     <= '0;
            mx3_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            m_q     <= m_d;
            mx3_q   <= mx3_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state; operands come straight from registers that
    // cannot change while a multiply is outstanding.
    always_comb begin
        bus.busy        = (state_q != StIdle);
        bus.done        = (state_q == StDone);
        bus.err         = err_q;
        bus.result      = res_q;
        bus.mm_enable_p = (state_q == StSqIssue) || (state_q == StMuIssue);
        bus.mm_a        = r_q;
        bus.mm_b        = ((state_q == StMuIssue) || (state_q == StMuWait)) ? base_q : r_q;
        bus.mm_m        = m_q;
        bus.mm_mx3      = mx3_q;
    end

endmodule
